uart_tx_frame: RTL and testbench

- UART transmit framer, directly downstream of the baud clock generator.
- Accepts bytes over a valid/ready handshake into a one-entry holding register and serialises them LSB-first onto `tx`: start bit, DATA_BITS data bits, optional parity, STOP_BITS stop bits.
- Runs entirely on the master clock; the generator's 50%-duty baud clock is used only as a rising-edge-detected bit-period enable.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_edge.sv | 27 ++
 rtl/uart_tx_frame.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS_DEF = 8;
    localparam int UART_STOP_BITS_DEF = 1;

endpackage

// File: rtl/uart_baud_edge.sv
// Turns the generator's 50%-duty baud clock into a one-clk bit-period enable.
// Kept separate so the receiver can reuse the same edge detector.
module uart_baud_edge (
    input  logic clk,
    input  logic rst,
    input  logic baud_clk,
    output logic tick
);

    logic baud_q;
    logic baud_d;

    always_comb begin
        baud_d = baud_clk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud_d;
        end
    end

    assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: one-entry holding register feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to compile in the parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEF,
    parameter int STOP_BITS  = UART_STOP_BITS_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_frame: unsupported DATA_BITS/STOP_BITS/PARITY_ODD");
    end

    logic tick;

    uart_baud_edge u_baud_edge (
        .clk      (clk),
        .rst      (rst),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 load;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        load         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        // Accept needs an empty hold register and load needs a full one, so they never collide.
        if (tx_valid && ready_q) begin
            hold_d       = tx_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                load = tick && hold_valid_q;
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q < LAST_BIT) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d       = parity_q;
                        state_d    = PARITY;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = '0;
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = '0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Loading the next byte drives the start bit immediately, which keeps queued frames gapless.
        if (load) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            tx_d         = 1'b0;
            busy_d       = 1'b1;
            state_d      = START;
`ifdef UART_TX_PARITY_EN
            parity_d     = (^hold_q) ^ 1'(PARITY_ODD);
`endif
        end

        ready_d = ~hold_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8N1, 8N2, 5-bit odd-parity variant) checked
// sample-by-sample against a frame model built from the bit sequence, 16 clk per bit.
module tb_uart_tx_frame;

    localparam int BIT_CLK = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_clk = 1'b0;
    logic       baud_en = 1'b1;
    int         baud_cnt = 0;
    logic [8:0] td [3];
    logic       tv [3];
    logic       rdy [3];
    logic       txl [3];
    logic       bsy [3];

    int   total = 0;
    int   bad = 0;
    int   last_latency = 0;
    logic exp_q [$];
    logic ready_log [$];

    always #5 clk = ~clk;

    // Baud clock is 8 clk high / 8 clk low, changed on the falling clk edge; baud_en freezes it.
    always @(negedge clk) begin
        if (baud_en) begin
            if (baud_cnt == 7) begin
                baud_cnt = 0;
                baud_clk = ~baud_clk;
            end else begin
                baud_cnt++;
            end
        end
    end

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(td[0][7:0]), .tx_valid(tv[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]));

    uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(td[1][7:0]), .tx_valid(tv[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]));

    uart_tx_frame #(.DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(td[2][4:0]), .tx_valid(tv[2]),
        .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]));

    task automatic push_bit(input logic v);
        for (int k = 0; k < BIT_CLK; k++) exp_q.push_back(v);
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop bits 1.
    task automatic add_frame(input int idx, input logic [8:0] d);
        int nd = (idx == 2) ? 5 : 8;
        int ns = (idx == 1) ? 2 : 1;
        int odd = (idx == 2) ? 1 : 0;
        logic [8:0] m = d & 9'((1 << nd) - 1);
        push_bit(1'b0);
        for (int i = 0; i < nd; i++) push_bit(m[i]);
        if (PAR_EN) push_bit(logic'((($countones(m) % 2) + odd) % 2));
        for (int s = 0; s < ns; s++) push_bit(1'b1);
    endtask

    task automatic send(input int idx, input logic [8:0] d);
        int w = 0;
        while (rdy[idx] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (rdy[idx] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL send_ready[%0d]: tx_ready=%b want 1", idx, rdy[idx]);
        end
        td[idx] = d;
        tv[idx] = 1'b1;
        @(negedge clk);
        tv[idx] = 1'b0;
    endtask

    // Waits for the start bit, then compares every clk against exp_q and checks the line idles after.
    task automatic check_wave(input int idx, input string name, input int budget);
        int waited = 0;
        int bad_at = -1;
        logic bad_tx = 1'b0;
        logic bad_busy = 1'b0;
        while (txl[idx] !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        last_latency = waited;
        total++;
        if (txl[idx] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_start: tx=%b want 0 within %0d clk", name, txl[idx], budget);
            return;
        end
        ready_log.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            ready_log.push_back(rdy[idx]);
            if (bad_at < 0 && (txl[idx] !== exp_q[i] || bsy[idx] !== 1'b1)) begin
                bad_at = i;
                bad_tx = txl[idx];
                bad_busy = bsy[idx];
            end
            @(negedge clk);
        end
        total++;
        if (bad_at >= 0) begin
            bad++;
            $display("[TB] FAIL %s_wave: at clk %0d tx=%b busy=%b want tx=%b busy=1",
                     name, bad_at, bad_tx, bad_busy, exp_q[bad_at]);
        end
        total++;
        if (txl[idx] !== 1'b1 || bsy[idx] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_end: tx=%b busy=%b want tx=1 busy=0", name, txl[idx], bsy[idx]);
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (txl[i] !== 1'b1 || bsy[i] !== 1'b0 || rdy[i] !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL reset_val[%0d]: tx=%b busy=%b ready=%b want 1/0/0",
                             i, txl[i], bsy[i], rdy[i]);
                end
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdy[i] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_ready[%0d]: ready=%b want 1", i, rdy[i]);
            end
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            total++;
            if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_line: tx=%b busy=%b want 1/0", txl[0], bsy[0]);
            end
        end
    endtask

    task automatic test_single();
        exp_q.delete();
        add_frame(0, 9'h0A5);
        send(0, 9'h0A5);
        check_wave(0, "single_a5", 40);
        total++;
        if (last_latency < 1 || last_latency > BIT_CLK) begin
            bad++;
            $display("[TB] FAIL single_latency: %0d clk want 1..%0d", last_latency, BIT_CLK);
        end
    endtask

    task automatic test_back_to_back(input int idx, input logic [8:0] a, input logic [8:0] b,
                                     input string name);
        int n1;
        exp_q.delete();
        add_frame(idx, a);
        n1 = exp_q.size();
        add_frame(idx, b);
        send(idx, a);
        fork
            check_wave(idx, name, 40);
            begin
                repeat (48) @(negedge clk);
                send(idx, b);
            end
        join
        total++;
        if (ready_log.size() != exp_q.size() || ready_log[0] !== 1'b1 ||
            ready_log[n1 - 1] !== 1'b0 || ready_log[n1] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_ready: log size %0d, ready around reload not 1..0|1",
                     name, ready_log.size());
        end
    endtask

    task automatic test_mid_reset();
        int w = 0;
        send(0, 9'h03C);
        while (txl[0] !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        repeat (16) @(negedge clk);
        send(0, 9'h099);
        repeat (88 - 17) @(negedge clk);
        total++;
        if (txl[0] !== 1'b1 || rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_bit4: tx=%b ready=%b busy=%b want 1/0/1", txl[0], rdy[0], bsy[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (txl[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset: tx=%b busy=%b ready=%b want 1/0/0", txl[0], bsy[0], rdy[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rdy[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_ready: ready=%b want 1", rdy[0]);
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            total++;
            if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL mid_no_frame: tx=%b busy=%b want 1/0", txl[0], bsy[0]);
            end
        end
        exp_q.delete();
        add_frame(0, 9'h081);
        send(0, 9'h081);
        check_wave(0, "recover_81", 40);
    endtask

    task automatic test_freeze();
        int w = 0;
        send(0, 9'h0F0);
        while (txl[0] !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        repeat (24) @(negedge clk);
        baud_en = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            total++;
            if (txl[0] !== 1'b0 || bsy[0] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL freeze_hold: tx=%b busy=%b want 0/1", txl[0], bsy[0]);
            end
        end
        baud_en = 1'b1;
        w = 0;
        while (bsy[0] !== 1'b0 && w < 250) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (bsy[0] !== 1'b0 || txl[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL freeze_resume: busy=%b tx=%b want 0/1", bsy[0], txl[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int idx = int'($urandom_range(0, 2));
            logic [8:0] d = 9'($urandom);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            exp_q.delete();
            add_frame(idx, d);
            send(idx, d);
            check_wave(idx, $sformatf("rand%0d_u%0d_%03h", n, idx, d), 40);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        exp_q.delete();
        add_frame(0, 9'h007);
        send(0, 9'h007);
        check_wave(0, "par_even_07", 40);
        exp_q.delete();
        add_frame(2, 9'h007);
        send(2, 9'h007);
        check_wave(2, "par_odd_07", 40);
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++) begin
            td[i] = '0;
            tv[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_back_to_back(0, 9'h000, 9'h0FF, "b2b_00_ff");
        test_back_to_back(1, 9'h055, 9'h0A3, "stop2_55");
        test_mid_reset();
        test_freeze();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
